// File: rtl/ga_pkg.sv
// Shared types and constants for the GA datapath blocks: chromosome type,
// crossover sequencer states and the LFSR polynomial used by the pairing logic.
package ga_pkg;

    typedef logic signed [7:0] chrom_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_P1,
        ST_RD_P2,
        ST_LATCH,
        ST_XOVER,
        ST_WR_C1,
        ST_WR_C2,
        ST_DONE
    } seq_state_t;

    // Galois right-shift toggle mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_POLY         = 8'hB8;
    localparam logic [7:0] DEFAULT_LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return {1'b0, value[7:1]} ^ (value[0] ? LFSR_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crossover_sequencer_if.sv
// Bus between the crossover sequencer and its environment: controller handshake,
// population RAM read port, crossover unit and next-generation buffer write port.
interface crossover_sequencer_if
    import ga_pkg::*;
#(
    parameter int ADDR_W = 4
);

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pop_rd_addr;
    chrom_t            pop_rd_data;
    chrom_t            xo_parent1;
    chrom_t            xo_parent2;
    logic              xo_enable;
    chrom_t            xo_child1;
    chrom_t            xo_child2;
    logic              nxt_wr_en;
    logic [ADDR_W-1:0] nxt_wr_addr;
    chrom_t            nxt_wr_data;
    logic [ADDR_W-1:0] pair_cnt;

    modport master (
        input  start, pop_rd_data, xo_child1, xo_child2,
        output busy, done, pop_rd_addr, xo_parent1, xo_parent2, xo_enable,
               nxt_wr_en, nxt_wr_addr, nxt_wr_data, pair_cnt
    );

    modport slave (
        output start, pop_rd_data, xo_child1, xo_child2,
        input  busy, done, pop_rd_addr, xo_parent1, xo_parent2, xo_enable,
               nxt_wr_en, nxt_wr_addr, nxt_wr_data, pair_cnt
    );

endinterface

// File: rtl/ga_lfsr.sv
// 8-bit Galois LFSR that steps once per cycle while advance is high.
// Shared by the pairing, selection and mutation blocks.
module ga_lfsr
    import ga_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= SEED;
        end else if (advance) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/crossover_sequencer.sv
// Sequences one generation of crossover: read parent pair, pulse the crossover
// unit, write both children. Define RANDOM_PAIR_EN for LFSR-driven parent selection.
module crossover_sequencer
    import ga_pkg::*;
#(
    parameter int         POP_SIZE  = 16,
    parameter int         ADDR_W    = $clog2(POP_SIZE),
    parameter logic [7:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crossover_sequencer_if.master seq
);

    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(POP_SIZE / 2 - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pair;
    logic [ADDR_W-1:0] r_rd_addr_hold;
    chrom_t            r_p1_q;
    chrom_t            r_p2_q;

    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_idx1;
    logic [ADDR_W-1:0] w_idx2;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_base = r_pair << 1;

`ifdef RANDOM_PAIR_EN
    logic [7:0] w_lfsr;
    logic       w_lfsr_adv;
    logic       w_unused_lfsr;

    // Steps after RD_P1 and after RD_P2, so idx2 sees the post-RD_P1 value.
    assign w_lfsr_adv = (r_state == ST_RD_P1) || (r_state == ST_RD_P2);

    ga_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .advance(w_lfsr_adv),
        .value  (w_lfsr)
    );

    assign w_idx1        = w_lfsr[ADDR_W-1:0];
    assign w_idx2        = w_lfsr[ADDR_W-1:0];
    assign w_unused_lfsr = ^w_lfsr;
`else
    logic w_unused_cfg;

    assign w_idx1       = w_base;
    assign w_idx2       = w_base | ADDR_W'(1);
    assign w_unused_cfg = ^LFSR_SEED;
`endif

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (seq.start) w_state_nxt = ST_RD_P1;
            ST_RD_P1: w_state_nxt = ST_RD_P2;
            ST_RD_P2: w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = ST_XOVER;
            ST_XOVER: w_state_nxt = ST_WR_C1;
            ST_WR_C1: w_state_nxt = ST_WR_C2;
            ST_WR_C2: w_state_nxt = (r_pair == LAST_PAIR) ? ST_DONE : ST_RD_P1;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no state leaves it unassigned (no latch).
    always_comb begin
        w_rd_addr       = r_rd_addr_hold;
        seq.xo_enable   = 1'b0;
        seq.nxt_wr_en   = 1'b0;
        seq.nxt_wr_addr = '0;
        seq.nxt_wr_data = '0;
        unique case (r_state)
            ST_RD_P1: w_rd_addr = w_idx1;
            ST_RD_P2: w_rd_addr = w_idx2;
            ST_XOVER: seq.xo_enable = 1'b1;
            ST_WR_C1: begin
                seq.nxt_wr_en   = 1'b1;
                seq.nxt_wr_addr = w_base;
                seq.nxt_wr_data = seq.xo_child1;
            end
            ST_WR_C2: begin
                seq.nxt_wr_en   = 1'b1;
                seq.nxt_wr_addr = w_base | ADDR_W'(1);
                seq.nxt_wr_data = seq.xo_child2;
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after its address, hence capture in RD_P2/LATCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair         <= '0;
            r_rd_addr_hold <= '0;
            r_p1_q         <= '0;
            r_p2_q         <= '0;
        end else begin
            r_rd_addr_hold <= w_rd_addr;
            if (r_state == ST_IDLE && seq.start) begin
                r_pair <= '0;
            end else if (r_state == ST_WR_C2 && r_pair != LAST_PAIR) begin
                r_pair <= r_pair + ADDR_W'(1);
            end
            if (r_state == ST_RD_P2) r_p1_q <= seq.pop_rd_data;
            if (r_state == ST_LATCH) r_p2_q <= seq.pop_rd_data;
        end
    end

    assign seq.busy        = (r_state != ST_IDLE);
    assign seq.done        = (r_state == ST_DONE);
    assign seq.pop_rd_addr = w_rd_addr;
    assign seq.xo_parent1  = r_p1_q;
    assign seq.xo_parent2  = r_p2_q;
    assign seq.pair_cnt    = r_pair;

endmodule

// File: tb/tb_crossover_sequencer.sv
// Self-checking bench: cycle-indexed reference model for a POP_SIZE=16 instance,
// plus literal checks on a POP_SIZE=4 instance.
`timescale 1ns/1ps
module tb_crossover_sequencer;

    localparam int N16   = 16;
    localparam int AW16  = 4;
    localparam int N4    = 4;
    localparam int AW4   = 2;
    localparam int GEN16 = 6 * (N16 / 2) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crossover_sequencer_if #(.ADDR_W(AW16)) bus16 ();
    crossover_sequencer_if #(.ADDR_W(AW4))  bus4 ();

    crossover_sequencer #(.POP_SIZE(N16), .LFSR_SEED(8'hA5)) dut16 (
        .clk(clk), .rst_n(rst_n), .seq(bus16)
    );
    crossover_sequencer #(.POP_SIZE(N4)) dut4 (
        .clk(clk), .rst_n(rst_n), .seq(bus4)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: RAMs, crossover units, write monitors
    logic [7:0] mem16 [N16];
    logic [7:0] mem4  [N4];
    logic       rd_ok16;
    int         wr_hits16 [N16];
    int         wr_total16 = 0;
    logic [AW4-1:0] wa4 [$];
    logic [7:0]     wd4 [$];
    int         xo4_cnt = 0;

    initial foreach (wr_hits16[i]) wr_hits16[i] = 0;

    // Data valid only in the cycle right after an RD_P1/RD_P2 address.
    always @(posedge clk) bus16.pop_rd_data <= rd_ok16 ? mem16[bus16.pop_rd_addr] : 8'hEE;
    always @(posedge clk) bus4.pop_rd_data  <= mem4[bus4.pop_rd_addr];

    always @(posedge clk) begin
        if (bus16.xo_enable) begin
            bus16.xo_child1 <= {bus16.xo_parent1[7:4], bus16.xo_parent2[3:0]};
            bus16.xo_child2 <= {bus16.xo_parent2[7:4], bus16.xo_parent1[3:0]};
        end
        if (bus4.xo_enable) begin
            bus4.xo_child1 <= {bus4.xo_parent1[7:4], bus4.xo_parent2[3:0]};
            bus4.xo_child2 <= {bus4.xo_parent2[7:4], bus4.xo_parent1[3:0]};
            xo4_cnt <= xo4_cnt + 1;
        end
        if (bus16.nxt_wr_en) begin
            wr_hits16[bus16.nxt_wr_addr] <= wr_hits16[bus16.nxt_wr_addr] + 1;
            wr_total16 <= wr_total16 + 1;
        end
        if (bus4.nxt_wr_en) begin
            wa4.push_back(bus4.nxt_wr_addr);
            wd4.push_back(bus4.nxt_wr_data);
        end
    end

    // ---------------- reference model for dut16 (cycle t counted from start-accept)
    int             t;
    logic [AW16-1:0] m_rd_hold, m_pcnt, m_i1, m_i2;
`ifdef RANDOM_PAIR_EN
    logic [7:0] m_lfsr;
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction
`endif

    task automatic model_step();
        logic            e_busy, e_done, e_xo, e_wr, chk_par;
        logic [AW16-1:0] e_rd, e_waddr;
        logic [7:0]      e_wdata;
        int              pair, ph;
        if (!rst_n) begin
            t = 0; m_rd_hold = '0; m_pcnt = '0; rd_ok16 = 1'b0;
`ifdef RANDOM_PAIR_EN
            m_lfsr = 8'hA5;
`endif
            check("rst_busy",    bus16.busy, 0);
            check("rst_done",    bus16.done, 0);
            check("rst_xo_en",   bus16.xo_enable, 0);
            check("rst_wr_en",   bus16.nxt_wr_en, 0);
            check("rst_rd_addr", bus16.pop_rd_addr, 0);
            check("rst_pair",    bus16.pair_cnt, 0);
            check("rst_par1",    $unsigned(bus16.xo_parent1), 0);
            check("rst_par2",    $unsigned(bus16.xo_parent2), 0);
            return;
        end
        e_busy = (t != 0); e_done = (t == GEN16); e_xo = 0; e_wr = 0;
        e_rd = m_rd_hold; e_waddr = '0; e_wdata = '0; chk_par = 0; ph = -1;
        if (t > 0 && t < GEN16) begin
            pair = (t - 1) / 6;
            ph = (t - 1) % 6;
            m_pcnt = AW16'(pair);
            case (ph)
                0: begin
`ifdef RANDOM_PAIR_EN
                    m_i1 = m_lfsr[AW16-1:0]; m_lfsr = lfsr_step(m_lfsr);
`else
                    m_i1 = AW16'(2 * pair);
`endif
                    e_rd = m_i1;
                end
                1: begin
`ifdef RANDOM_PAIR_EN
                    m_i2 = m_lfsr[AW16-1:0]; m_lfsr = lfsr_step(m_lfsr);
`else
                    m_i2 = AW16'(2 * pair + 1);
`endif
                    e_rd = m_i2;
                end
                3: begin e_xo = 1; chk_par = 1; end
                4: begin
                    e_wr = 1; chk_par = 1; e_waddr = AW16'(2 * pair);
                    e_wdata = {mem16[m_i1][7:4], mem16[m_i2][3:0]};
                end
                5: begin
                    e_wr = 1; chk_par = 1; e_waddr = AW16'(2 * pair + 1);
                    e_wdata = {mem16[m_i2][7:4], mem16[m_i1][3:0]};
                end
                default: ;
            endcase
        end
        m_rd_hold = e_rd;
        check("busy",     bus16.busy, e_busy);
        check("done",     bus16.done, e_done);
        check("xo_en",    bus16.xo_enable, e_xo);
        check("wr_en",    bus16.nxt_wr_en, e_wr);
        check("rd_addr",  bus16.pop_rd_addr, e_rd);
        check("pair_cnt", bus16.pair_cnt, m_pcnt);
        if (e_wr) begin
            check("wr_addr", bus16.nxt_wr_addr, e_waddr);
            check("wr_data", $unsigned(bus16.nxt_wr_data), e_wdata);
        end
        if (chk_par) begin
            check("parent1", $unsigned(bus16.xo_parent1), mem16[m_i1]);
            check("parent2", $unsigned(bus16.xo_parent2), mem16[m_i2]);
        end
        rd_ok16 = (ph == 0 || ph == 1);
        if (t == 0)          t = bus16.start ? 1 : 0;
        else if (t == GEN16) t = 0;
        else                 t++;
    endtask

    // Every stimulus step advances through here, so the model sees every cycle.
    task automatic next_cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done16(output int c);
        c = 1;
        while (!bus16.done && c < 200) begin
            next_cycle();
            c++;
        end
    endtask

    int hits_base [N16];
    int c, nbusy, ndone, total_base;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus16.start = 1'b0;
        bus4.start  = 1'b0;
        mem4[0] = 8'h12; mem4[1] = 8'hAB; mem4[2] = 8'h3C; mem4[3] = 8'hF0;
        for (int i = 0; i < N16; i++) mem16[i] = 8'(i * 8'h29 + 8'h07);
        mem16[0] = 8'h12; mem16[1] = 8'hAB; mem16[2] = 8'h3C; mem16[3] = 8'hF0;
        repeat (3) next_cycle();
        check("rst_busy4", bus4.busy, 0);
        check("rst_pair4", bus4.pair_cnt, 0);
        rst_n = 1'b1;
        next_cycle();

        // ---- POP_SIZE=4 generation with literal expectations
        bus4.start = 1'b1;
        next_cycle();
        bus4.start = 1'b0;
        c = 1;
        while (!bus4.done && c < 100) begin
            next_cycle();
            c++;
        end
        check("p4_done_cycle", c, 13);
        check("p4_writes", wa4.size(), 4);
        check("p4_xo_pulses", xo4_cnt, 2);
`ifndef RANDOM_PAIR_EN
        if (wa4.size() == 4) begin
            check("p4_addr0", wa4[0], 0); check("p4_data0", wd4[0], 8'h1B);
            check("p4_addr1", wa4[1], 1); check("p4_data1", wd4[1], 8'hA2);
            check("p4_addr2", wa4[2], 2); check("p4_data2", wd4[2], 8'h30);
            check("p4_addr3", wa4[3], 3); check("p4_data3", wd4[3], 8'hFC);
        end
`endif
        next_cycle();
        check("p4_done_pulse", bus4.done, 0);
        check("p4_idle", bus4.busy, 0);

        // ---- POP_SIZE=16 with start held high across the whole generation
        for (int i = 0; i < N16; i++) hits_base[i] = wr_hits16[i];
        bus16.start = 1'b1;
        next_cycle();
        c = 1; nbusy = 0; ndone = 0;
        while (1) begin
            if (bus16.busy) nbusy++;
            if (bus16.done) ndone++;
`ifdef RANDOM_PAIR_EN
            if (c == 1) check("lit_idx1", bus16.pop_rd_addr, 5);
            if (c == 2) check("lit_idx2", bus16.pop_rd_addr, 10);
`else
            if (c == 1) check("lit_idx1", bus16.pop_rd_addr, 0);
            if (c == 2) check("lit_idx2", bus16.pop_rd_addr, 1);
            if (c == 5) check("lit_child1", $unsigned(bus16.nxt_wr_data), 8'h1B);
`endif
            if (bus16.done || c >= 200) break;
            next_cycle();
            c++;
        end
        check("g1_done_cycle", c, 49);
        check("g1_busy_cycles", nbusy, 49);
        check("g1_done_count", ndone, 1);
        for (int i = 0; i < N16; i++) check("g1_addr_once", wr_hits16[i] - hits_base[i], 1);
        next_cycle();
        check("g1_idle_gap", bus16.busy, 0);
        check("g1_done_pulse", bus16.done, 0);

        // Still high in IDLE, so a second generation starts here.
        for (int i = 0; i < N16; i++) hits_base[i] = wr_hits16[i];
        next_cycle();
        bus16.start = 1'b0;
        check("g2_restart", bus16.busy, 1);
        wait_done16(c);
        check("g2_done_cycle", c, 49);
        for (int i = 0; i < N16; i++) check("g2_addr_once", wr_hits16[i] - hits_base[i], 1);
        next_cycle();

        // ---- asynchronous reset during WR_C1 of pair 2
        bus16.start = 1'b1;
        next_cycle();
        bus16.start = 1'b0;
        c = 0;
        while (!(bus16.nxt_wr_en && bus16.nxt_wr_addr == 4'd4) && c < 100) begin
            next_cycle();
            c++;
        end
        check("rst_mid_found", c < 100, 1);
        check("rst_mid_pair", bus16.pair_cnt, 2);
        total_base = wr_total16;
        rst_n = 1'b0;
        #1;
        check("async_busy",  bus16.busy, 0);
        check("async_wr_en", bus16.nxt_wr_en, 0);
        check("async_pair",  bus16.pair_cnt, 0);
        check("async_rd",    bus16.pop_rd_addr, 0);
        check("async_par1",  $unsigned(bus16.xo_parent1), 0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (10) next_cycle();
        check("post_rst_writes", wr_total16 - total_base, 0);
        check("post_rst_idle", bus16.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
